// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared types and constants for the QBUS RAM target
package qbus_pkg;

    // Bus strobes are active-low.
    localparam logic QB_ASSERT = 1'b0;
    localparam logic QB_NEGATE = 1'b1;

    // Width of the RPLY wait counter (RPLY_DELAY range 0..15).
    localparam int QB_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_NOSEL,
        ST_RD_WAIT,
        ST_RD_RPLY,
        ST_WR_WAIT,
        ST_WR_RPLY,
        ST_DONE
    } qb_state_t;

endpackage

// File: rtl/qbus_ram_slave_if.sv
// rtl/qbus_ram_slave_if.sv - QBUS-style bus bundle between CPU master and RAM target
//
// Signals: sync/din/dout (active-low strobes), wtbt (0 = byte, 1 = word write),
// ad_i (AD as seen at pads), ad_o/ad_oe (read data and drive enable),
// rply (active-low reply). With QBUS_RAM_WRPROT_EN defined, wp adds write protect.
interface qbus_ram_slave_if;
    logic        sync;
    logic        din;
    logic        dout;
    logic        wtbt;
    logic [15:0] ad_i;
    logic [15:0] ad_o;
    logic        ad_oe;
    logic        rply;
`ifdef QBUS_RAM_WRPROT_EN
    logic        wp;

    modport master (output sync, din, dout, wtbt, ad_i, wp,
                    input  ad_o, ad_oe, rply);
    modport slave  (input  sync, din, dout, wtbt, ad_i, wp,
                    output ad_o, ad_oe, rply);
`else
    modport master (output sync, din, dout, wtbt, ad_i,
                    input  ad_o, ad_oe, rply);
    modport slave  (input  sync, din, dout, wtbt, ad_i,
                    output ad_o, ad_oe, rply);
`endif
endinterface

// File: rtl/qbus_ram_core.sv
// rtl/qbus_ram_core.sv - single-port synchronous RAM, 16-bit words, byte enables, registered read
//
// Ports: clk; we + be[1:0] write enables (be[0] = low byte, be[1] = high byte);
// addr word index; wdata write word; re read enable; rdata registered read word.
module qbus_ram_core #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [1:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           wdata,
    input  logic                  re,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we && be[0]) begin
            mem[addr][7:0] <= wdata[7:0];
        end
        if (we && be[1]) begin
            mem[addr][15:8] <= wdata[15:8];
        end
        // rdata holds between reads so it stays stable through the reply phase.
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/qbus_ram_slave.sv
// rtl/qbus_ram_slave.sv - on-chip RAM target answering QBUS DIN/DOUT cycles with RPLY
//
// Ports: clk; reset (synchronous, active-high); bus (slave modport: sync, din,
// dout, wtbt, ad_i in; ad_o, ad_oe, rply out).
// Optional: QBUS_RAM_WRPROT_EN adds bus.wp; wp==1 at the write edge suppresses
// the RAM update while the handshake still completes.
module qbus_ram_slave
    import qbus_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int          RPLY_DELAY = 1
) (
    input  logic              clk,
    input  logic              reset,
    qbus_ram_slave_if.slave   bus
);

    qb_state_t             state, state_nx;
    logic [QB_CNT_W-1:0]   cnt, cnt_nx;
    logic [15:0]           addr_lat;
    logic                  sel;
    logic                  ram_re;
    logic                  ram_we;
    logic                  ram_we_eff;
    logic [1:0]            ram_be;
    logic [15:0]           ram_q;

    // The address phase is whatever AD carried on the last edge before SYNC fell.
    always_ff @(posedge clk) begin
        if (bus.sync == QB_NEGATE) begin
            addr_lat <= bus.ad_i;
        end
    end

    assign sel = (addr_lat[15:ADDR_WIDTH+1] == BASE_ADDR[15:ADDR_WIDTH+1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.sync == QB_ASSERT) begin
                    state_nx = sel ? ST_ADDR : ST_NOSEL;
                end
            end
            ST_NOSEL: begin
                if (bus.sync == QB_NEGATE) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.sync == QB_NEGATE) begin
                    state_nx = ST_IDLE;
                end else if (bus.din == QB_ASSERT && bus.dout == QB_NEGATE) begin
                    ram_re   = 1'b1;
                    cnt_nx   = QB_CNT_W'(RPLY_DELAY);
                    state_nx = ST_RD_WAIT;
                end else if (bus.dout == QB_ASSERT && bus.din == QB_NEGATE) begin
                    ram_we   = 1'b1;
                    cnt_nx   = QB_CNT_W'(RPLY_DELAY);
                    state_nx = ST_WR_WAIT;
                end
                // Both strobes low is a master error: wait here without replying.
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (bus.sync == QB_NEGATE) begin
                    state_nx = ST_IDLE;
                end else if (cnt == '0) begin
                    state_nx = (state == ST_RD_WAIT) ? ST_RD_RPLY : ST_WR_RPLY;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_RD_RPLY: begin
                if (bus.sync == QB_NEGATE) begin
                    state_nx = ST_IDLE;
                end else if (bus.din == QB_NEGATE) begin
                    state_nx = ST_DONE;
                end
            end
            ST_WR_RPLY: begin
                if (bus.sync == QB_NEGATE) begin
                    state_nx = ST_IDLE;
                end else if (bus.dout == QB_NEGATE) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.sync == QB_NEGATE) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Word writes take both lanes; byte writes pick the lane from the odd address bit.
    always_comb begin
        ram_be = 2'b00;
        if (bus.wtbt) begin
            ram_be = 2'b11;
        end else if (addr_lat[0]) begin
            ram_be = 2'b10;
        end else begin
            ram_be = 2'b01;
        end
    end

`ifdef QBUS_RAM_WRPROT_EN
    assign ram_we_eff = ram_we & ~bus.wp;
`else
    assign ram_we_eff = ram_we;
`endif

    qbus_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .we    (ram_we_eff),
        .be    (ram_be),
        .addr  (addr_lat[ADDR_WIDTH:1]),
        .wdata (bus.ad_i),
        .re    (ram_re),
        .rdata (ram_q)
    );

    assign bus.rply  = (state == ST_RD_RPLY || state == ST_WR_RPLY) ? QB_ASSERT : QB_NEGATE;
    assign bus.ad_oe = (state == ST_RD_RPLY);
    assign bus.ad_o  = (state == ST_RD_RPLY) ? ram_q : 16'h0000;

endmodule

// File: tb/tb_qbus_ram_slave.sv
// tb/tb_qbus_ram_slave.sv - self-checking bench for qbus_ram_slave
module tb_qbus_ram_slave;
    import qbus_pkg::*;

    localparam int AW    = 12;
    localparam int DELAY = 1;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    // Reference memory: word index -> expected 16-bit contents.
    logic [15:0] model [int];

    qbus_ram_slave_if bus ();

    qbus_ram_slave #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (16'h0000),
        .RPLY_DELAY (DELAY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [15:0] addr);
        return int'(addr[AW:1]);
    endfunction

    function automatic void model_write(input logic [15:0] addr, input logic [15:0] data,
                                        input logic wtbt);
        logic [15:0] w;
        w = model.exists(widx(addr)) ? model[widx(addr)] : 16'hxxxx;
        if (wtbt)         w = data;
        else if (addr[0]) w[15:8] = data[15:8];
        else              w[7:0] = data[7:0];
        model[widx(addr)] = w;
    endfunction

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data,
                            output int lat, output logic oe, output logic rel);
        bus.ad_i = addr; bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1;
        step();
        bus.sync = 1'b0;
        step();
        bus.din = 1'b0;
        step();
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.rply === 1'b0) begin
                lat = i;
                break;
            end
        end
        data = bus.ad_o;
        oe   = bus.ad_oe;
        bus.din = 1'b1;
        step();
        rel = bus.rply;
        bus.sync = 1'b1;
        step();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                             input logic wtbt, output int lat, output logic rel);
        bus.ad_i = addr; bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1;
        step();
        bus.sync = 1'b0;
        step();
        bus.ad_i = data; bus.wtbt = wtbt; bus.dout = 1'b0;
        step();
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.rply === 1'b0) begin
                lat = i;
                break;
            end
        end
        bus.dout = 1'b1;
        step();
        rel = bus.rply;
        bus.sync = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int          lat;
        logic        oe, rel;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.rply !== 1'b1) begin errors++; $display("FAIL reset_rply got=%b exp=1", bus.rply); end
        checks++; if (bus.ad_oe !== 1'b0) begin errors++; $display("FAIL reset_ad_oe got=%b exp=0", bus.ad_oe); end
        checks++; if (bus.ad_o !== 16'h0000) begin errors++; $display("FAIL reset_ad_o got=%h exp=0000", bus.ad_o); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        bus_read(16'h0FFE, d, lat, oe, rel);
        checks++; if (lat !== DELAY + 1) begin errors++; $display("FAIL unwritten_read_lat got=%0d exp=%0d", lat, DELAY + 1); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL unwritten_read_oe got=%b exp=1", oe); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL unwritten_read_release got=%b exp=1", rel); end
    endtask

    task automatic test_word_rw();
        logic [15:0] d;
        int          lat;
        logic        oe, rel;
        bus_write(16'h0100, 16'hBEEF, 1'b1, lat, rel);
        model_write(16'h0100, 16'hBEEF, 1'b1);
        checks++; if (lat !== DELAY + 1) begin errors++; $display("FAIL word_write_lat got=%0d exp=%0d", lat, DELAY + 1); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL word_write_release got=%b exp=1", rel); end
        bus_read(16'h0100, d, lat, oe, rel);
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL word_read_data got=%h exp=BEEF", d); end
        checks++; if (lat !== DELAY + 1) begin errors++; $display("FAIL word_read_lat got=%0d exp=%0d", lat, DELAY + 1); end
        checks++; if (rel !== 1'b1) begin errors++; $display("FAIL word_read_release got=%b exp=1", rel); end
    endtask

    task automatic test_byte_write();
        logic [15:0] d;
        int          lat;
        logic        oe, rel;
        bus_write(16'h0101, 16'h5500, 1'b0, lat, rel);
        model_write(16'h0101, 16'h5500, 1'b0);
        bus_read(16'h0100, d, lat, oe, rel);
        checks++; if (d !== 16'h55EF) begin errors++; $display("FAIL byte_hi_data got=%h exp=55EF", d); end
        bus_write(16'h0100, 16'h0011, 1'b0, lat, rel);
        model_write(16'h0100, 16'h0011, 1'b0);
        bus_read(16'h0100, d, lat, oe, rel);
        checks++; if (d !== 16'h5511) begin errors++; $display("FAIL byte_lo_data got=%h exp=5511", d); end
        bus_write(16'h0100, 16'h55EF, 1'b1, lat, rel);
        model_write(16'h0100, 16'h55EF, 1'b1);
    endtask

    task automatic test_nosel();
        int bad;
        bus.ad_i = 16'h2000; bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1;
        step();
        bus.sync = 1'b0;
        step();
        checks++; if (dut.state !== ST_NOSEL) begin errors++; $display("FAIL nosel_state got=%0d exp=%0d", dut.state, ST_NOSEL); end
        bus.din = 1'b0;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (bus.rply !== 1'b1 || bus.ad_oe !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL nosel_quiet got=%0d active cycles exp=0", bad); end
        bus.din = 1'b1; bus.sync = 1'b1;
        step();
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL nosel_exit got=%0d exp=%0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_proto_error();
        int bad;
        bus.ad_i = 16'h0200; bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1;
        step();
        bus.sync = 1'b0;
        step();
        bus.din = 1'b0; bus.dout = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.rply !== 1'b1 || bus.ad_oe !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL proto_err_quiet got=%0d exp=0", bad); end
        bus.din = 1'b1; bus.dout = 1'b1; bus.sync = 1'b1;
        step();
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL proto_err_exit got=%0d exp=%0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_abort_write();
        logic [15:0] d;
        int          lat;
        logic        oe, rel;
        bus.ad_i = 16'h0300; bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1;
        step();
        bus.sync = 1'b0;
        step();
        bus.ad_i = 16'hA5C3; bus.wtbt = 1'b1; bus.dout = 1'b0;
        step();
        model_write(16'h0300, 16'hA5C3, 1'b1);
        bus.dout = 1'b1; bus.sync = 1'b1;
        step();
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        checks++; if (bus.rply !== 1'b1) begin errors++; $display("FAIL abort_rply got=%b exp=1", bus.rply); end
        bus_read(16'h0300, d, lat, oe, rel);
        checks++; if (d !== model[widx(16'h0300)]) begin errors++; $display("FAIL abort_write_stands got=%h exp=%h", d, model[widx(16'h0300)]); end
    endtask

    task automatic test_reset_in_rply();
        logic [15:0] d;
        int          lat;
        logic        oe, rel;
        bus.ad_i = 16'h0100; bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1;
        step();
        bus.sync = 1'b0;
        step();
        bus.din = 1'b0;
        for (int i = 0; i < DELAY + 2; i++) step();
        checks++; if (bus.rply !== 1'b0) begin errors++; $display("FAIL pre_reset_rply got=%b exp=0", bus.rply); end
        reset = 1'b1;
        step();
        checks++; if (bus.rply !== 1'b1) begin errors++; $display("FAIL midreset_rply got=%b exp=1", bus.rply); end
        checks++; if (bus.ad_oe !== 1'b0) begin errors++; $display("FAIL midreset_ad_oe got=%b exp=0", bus.ad_oe); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL midreset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        reset = 1'b0; bus.din = 1'b1; bus.sync = 1'b1;
        step();
        bus_read(16'h0100, d, lat, oe, rel);
        checks++; if (d !== 16'h55EF) begin errors++; $display("FAIL after_reset_read got=%h exp=55EF", d); end
    endtask

    task automatic test_random();
        logic [15:0] d, a, v;
        int          lat;
        logic        oe, rel, wt;
        for (int k = 0; k < 16; k++) begin
            a = 16'h0400 + 16'(k * 2);
            v = 16'($urandom);
            bus_write(a, v, 1'b1, lat, rel);
            model_write(a, v, 1'b1);
        end
        for (int n = 0; n < 40; n++) begin
            a = 16'h0400 + 16'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                v  = 16'($urandom);
                wt = 1'($urandom_range(0, 1));
                bus_write(a, v, wt, lat, rel);
                model_write(a, v, wt);
                checks++; if (lat !== DELAY + 1 || rel !== 1'b1) begin errors++; $display("FAIL rand_write lat=%0d rel=%b exp lat=%0d rel=1", lat, rel, DELAY + 1); end
            end else begin
                bus_read(a, d, lat, oe, rel);
                checks++; if (d !== model[widx(a)] || lat !== DELAY + 1) begin errors++; $display("FAIL rand_read addr=%h got=%h lat=%0d exp=%h lat=%0d", a, d, lat, model[widx(a)], DELAY + 1); end
            end
        end
        for (int k = 0; k < 16; k++) begin
            a = 16'h0400 + 16'(k * 2);
            bus_read(a, d, lat, oe, rel);
            checks++; if (d !== model[widx(a)]) begin errors++; $display("FAIL rand_final addr=%h got=%h exp=%h", a, d, model[widx(a)]); end
        end
    endtask

`ifdef QBUS_RAM_WRPROT_EN
    task automatic test_wrprot();
        logic [15:0] d;
        int          lat;
        logic        oe, rel;
        bus.wp = 1'b1;
        bus_write(16'h0100, 16'h1234, 1'b1, lat, rel);
        bus.wp = 1'b0;
        checks++; if (lat !== DELAY + 1 || rel !== 1'b1) begin errors++; $display("FAIL wrprot_handshake lat=%0d rel=%b exp lat=%0d rel=1", lat, rel, DELAY + 1); end
        bus_read(16'h0100, d, lat, oe, rel);
        checks++; if (d !== 16'h55EF) begin errors++; $display("FAIL wrprot_data got=%h exp=55EF", d); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.sync = 1'b1; bus.din = 1'b1; bus.dout = 1'b1; bus.wtbt = 1'b1;
        bus.ad_i = 16'h0000;
`ifdef QBUS_RAM_WRPROT_EN
        bus.wp = 1'b0;
`endif
        test_reset();
        test_word_rw();
        test_byte_write();
        test_nosel();
        test_proto_error();
        test_abort_write();
        test_reset_in_rply();
`ifdef QBUS_RAM_WRPROT_EN
        test_wrprot();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
